mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Sequences the single byte-wide RAM/IO port of riscv_top between two requesters.
// - Requester IF is instruction fetch: 4-byte reads. Requester LS is the load/store unit: 1/2/4-byte reads and writes.
// - Splits each request into byte cycles, assembles/disassembles little-endian words and returns a one-cycle done pulse.
// - Sits between the core (fetch, LSB) and the top-level mem_din/mem_dout/mem_a/mem_wr pins.
// PARAMETERS
// - ADDR_W     32       address width
// - STARVE_MAX 2        consecutive LS grants allowed while IF waits before IF is forced
// - IO_BASE    32'h30000 start of IO region (addr[17:16]==2'b11 decode)
// PORTS
// - clk_in        in   1   clock, rising edge
// - rst_in        in   1   asynchronous, active-high reset
// - rdy_in        in   1   global ready; 0 = freeze all state, outputs held
// - clear_in      in   1   pipeline flush (mispredict)
// - if_req        in   1   fetch request (level, held until if_done)
// - if_addr       in   32  fetch address
// - if_done       out  1   one-cycle pulse, if_data valid
// - if_data       out  32  fetched word
// - ls_req        in   1   load/store request (level, held until ls_done)
// - ls_wr         in   1   1 = store
// - ls_size       in   2   bytes-1: 0=1B, 1=2B, 3=4B (2 illegal, treated as 4B)
// - ls_addr       in   32  byte address
// - ls_wdata      in   32  store data, LSB first
// - ls_done       out  1   one-cycle pulse
// - ls_rdata      out  32  load data, zero-extended (sign-extension by LSB)
// - mem_din       in   8   RAM read byte, valid one cycle after address
// - mem_dout      out  8   RAM write byte
// - mem_a         out  32  RAM byte address
// - mem_wr        out  1   1 = write strobe this cycle
// - io_buffer_full in  1   UART TX buffer full
// BEHAVIOUR
// - Reset: state=IDLE; mem_a=0, mem_wr=0, mem_dout=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0; starve_cnt=0.
// - States: IDLE, READ, WRITE. All outputs are registered.
// - IDLE: if_req/ls_req sampled at edge E0. Grant goes to LS unless IF is also requesting and starve_cnt==STARVE_MAX; then IF.
//   Granting LS while IF requests increments starve_cnt. Granting IF clears it.
// - READ of N bytes: byte k on mem_a (mem_wr=0) in cycle k+1 after E0. mem_din captured one cycle later into byte lane k.
//   done pulse and data are visible N+2 cycles after E0; state returns to IDLE in the same cycle.
// - WRITE of N bytes: byte k on mem_a/mem_dout with mem_wr=1 in cycle k+1. ls_done visible N+1 cycles after E0.
// - Addresses: mem_a = base+k, 32-bit wrap (0xFFFFFFFF+1 -> 0). Outside a transfer mem_a=0, mem_wr=0.
// - done pulses last exactly 1 cycle. Requester must drop req on done; req seen high in the cycle after done starts a new request.
// - Back-to-back: with both requesters pending, LS,LS,IF order when STARVE_MAX=2.
// - clear_in (sampled high): aborts in-flight READ (IF or LS) -> IDLE next cycle, no done, partial data dropped.
//   A WRITE in progress completes and still pulses ls_done. clear_in in IDLE blocks grant that cycle.
// - rdy_in=0: no state/counter/output change. A byte already addressed has its mem_din captured in the first cycle rdy_in returns 1.
// - Async reset mid-transfer: immediate IDLE, outputs to reset values, transfer lost.
// CONFIGURATION
// - MEM_ARB_IO_STALL_EN defined:
//   - WRITE whose byte address is in the IO region: before each byte, stall (mem_wr=0, counter held) while io_buffer_full=1.
//   - Issue that byte in the first cycle io_buffer_full=0. ls_done is delayed by the stall cycles.
// - Not defined: io_buffer_full ignored. The port remains present and unconnected internally.
// TESTING
// - Reset: rst_in=1 async mid-cycle -> all outputs 0 before next edge. Hold 5 cycles -> no mem_wr.
// - IF read 0x1000, RAM holds 13 00 00 00 at 0x1000..3 -> mem_a 0x1000..0x1003 -> if_data=0x00000013, if_done pulse at cycle 6.
// - LS store size=3 addr 0x2000 wdata 0xDEADBEEF -> mem_wr 4 cycles, bytes EF,BE,AD,DE -> ls_done at cycle 5.
// - Both req held continuously (1B LS loads, IF reads) -> grants LS,LS,IF,LS,LS,IF. IF never waits >2 grants.
// - IF read, clear_in at cycle 2 -> no if_done, IDLE at cycle 3. Repeat as LS 1B store -> ls_done still pulses.
// - MEM_ARB_IO_STALL_EN: store 1B to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr low 3 cycles, then byte written, ls_done 3 cycles late.
//   Without the macro: written immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial sequencer for the shared RAM/IO port, arbitrating instruction fetch against load/store.
// Build option MEM_ARB_IO_STALL_EN: hold IO-region store bytes while io_buffer_full is high.
module mem_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                STARVE_MAX = 2,
    parameter logic [ADDR_W-1:0] IO_BASE    = 32'h30000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic              owner_ls_q, owner_ls_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic [2:0]        size_len;
    logic [2:0]        issue_idx;
    logic [1:0]        cap_idx;
    logic              wr_try;
    logic              io_region;
    logic              stall;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        starve_d   = starve_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        size_len   = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
        issue_idx  = cnt_q + 3'd1;
        cap_idx    = cnt_q[1:0] - 2'd1;
        wr_try     = 1'b0;
        io_region  = 1'b0;
        stall      = 1'b0;
        wr_addr    = '0;

        case (state_q)
            IDLE: begin
                mem_a_d    = '0;
                mem_wr_d   = 1'b0;
                mem_dout_d = '0;
                if (!clear_in && (ls_req || if_req)) begin
                    cnt_d = 3'd0;
                    buf_d = '0;
                    if (ls_req && !(if_req && starve_q == SW'(STARVE_MAX))) begin
                        owner_ls_d = 1'b1;
                        base_d     = ls_addr;
                        len_d      = size_len;
                        wdata_d    = ls_wdata;
                        if (if_req) starve_d = starve_q + SW'(1);
                        if (ls_wr) begin
                            state_d = WRITE;
                            wr_try  = 1'b1;
                        end else begin
                            state_d = READ;
                            mem_a_d = ls_addr;
                        end
                    end else begin
                        owner_ls_d = 1'b0;
                        base_d     = if_addr;
                        len_d      = 3'd4;
                        starve_d   = '0;
                        state_d    = READ;
                        mem_a_d    = if_addr;
                    end
                end
            end
            READ: begin
                mem_wr_d   = 1'b0;
                mem_dout_d = '0;
                if (clear_in) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                    cnt_d   = 3'd0;
                end else begin
                    // cnt_q counts edges since grant: byte cnt_q+1 goes out, byte cnt_q-1 comes back
                    mem_a_d = (issue_idx < len_q) ? base_q + ADDR_W'(issue_idx) : '0;
                    if (cnt_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    cnt_d = issue_idx;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                        cnt_d   = 3'd0;
                        if (owner_ls_q) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = buf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = buf_d;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt_q == len_q) begin
                    state_d    = IDLE;
                    ls_done_d  = 1'b1;
                    mem_a_d    = '0;
                    mem_wr_d   = 1'b0;
                    mem_dout_d = '0;
                    cnt_d      = 3'd0;
                end else begin
                    wr_try = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Store bytes are issued from here both at grant and while in WRITE; cnt counts bytes issued
        if (wr_try) begin
            wr_addr   = base_d + ADDR_W'(cnt_d);
            io_region = ((wr_addr & IO_BASE) == IO_BASE);
`ifdef MEM_ARB_IO_STALL_EN
            stall = io_region && io_buffer_full;
`else
            stall = 1'b0;
`endif
            if (stall) begin
                mem_a_d    = '0;
                mem_wr_d   = 1'b0;
                mem_dout_d = '0;
            end else begin
                mem_a_d    = wr_addr;
                mem_wr_d   = 1'b1;
                mem_dout_d = wdata_d[{cnt_d[1:0], 3'b000} +: 8];
                cnt_d      = cnt_d + 3'd1;
            end
        end
    end

`ifndef MEM_ARB_IO_STALL_EN
    logic unused_io;
    assign unused_io = io_region ^ io_buffer_full;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            starve_q   <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            starve_q   <= starve_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a registered-read byte RAM model and expectation queues.
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    logic [39:0] exp_wr_q[$];
    logic [32:0] exp_s_q[$];

    logic [31:0] a_tr[0:39];
    logic        wr_tr[0:39];
    logic [7:0]  d_tr[0:39];

    logic [7:0]  wram[0:65535];
    bit          written[0:65535];

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h13;
            16'h3000: return 8'h12;
            16'h3001: return 8'h34;
            16'h3002: return 8'h56;
            16'h3003: return 8'h78;
            16'hFFFF: return 8'hA5;
            16'h0000: return 8'h3C;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return written[a] ? wram[a] : init_byte(a);
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) begin
            wram[mem_a[15:0]]    <= mem_dout;
            written[mem_a[15:0]] <= 1'b1;
        end
        mem_din <= ram_rd(mem_a[15:0]);
    end

    task automatic run_txn(input bit use_ls, input bit wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int clear_at, input int full_cycles, input int freeze_at,
                           output int done_cyc, output logic [31:0] rdata);
        done_cyc = 0;
        rdata = '0;
        for (int i = 0; i < 40; i++) begin
            a_tr[i] = '0; wr_tr[i] = 1'b0; d_tr[i] = '0;
        end
        @(negedge clk_in);
        io_buffer_full = (full_cycles > 0);
        if (use_ls) begin
            ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c < 40; c++) begin
            @(negedge clk_in);
            a_tr[c] = mem_a; wr_tr[c] = mem_wr; d_tr[c] = mem_dout;
            io_buffer_full = (c < full_cycles);
            rdy_in = !(freeze_at > 0 && (c == freeze_at || c == freeze_at + 1));
            clear_in = (c == clear_at);
            if (clear_in && !wr) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
            if ((use_ls && ls_done) || (!use_ls && if_done)) begin
                done_cyc = c;
                rdata = use_ls ? ls_rdata : if_data;
                if_req = 1'b0; ls_req = 1'b0;
                break;
            end
        end
        clear_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        total++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
            bad++; $display("FAIL reset_mem: a=%h wr=%b dout=%h want 0/0/0", mem_a, mem_wr, mem_dout);
        end
        total++;
        if (if_done !== 1'b0 || ls_done !== 1'b0) begin
            bad++; $display("FAIL reset_done: if=%b ls=%b want 0/0", if_done, ls_done);
        end
        total++;
        if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_data: if=%h ls=%h want 0/0", if_data, ls_rdata);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_if_read();
        int dc; logic [31:0] rd; logic [31:0] e;
        exp_q.push_back(32'h00000013);
        run_txn(1'b0, 1'b0, 2'd3, 32'h1000, 32'h0, 0, 0, 0, dc, rd);
        total++;
        if (dc !== 6) begin bad++; $display("FAIL if_done_cycle: got %0d want 6", dc); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_tr[k+1] !== 32'h1000 + k || wr_tr[k+1] !== 1'b0) begin
                bad++; $display("FAIL if_addr_seq[%0d]: a=%h wr=%b want %h/0", k, a_tr[k+1], wr_tr[k+1], 32'h1000 + k);
            end
        end
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin bad++; $display("FAIL if_data: got %h want %h", rd, e); end
        @(negedge clk_in);
        total++;
        if (if_done !== 1'b0) begin bad++; $display("FAIL if_done_width: got %b want 0", if_done); end
        exp_q.push_back(32'h78563412);
        run_txn(1'b1, 1'b0, 2'd2, 32'h3000, 32'h0, 0, 0, 0, dc, rd);
        e = exp_q.pop_front();
        total++;
        if (dc !== 6 || rd !== e) begin
            bad++; $display("FAIL ls_read_size2: cyc=%0d data=%h want 6/%h", dc, rd, e);
        end
    endtask

    task automatic test_ls_store();
        int dc; int n; logic [31:0] rd; logic [39:0] e; logic [31:0] ed;
        exp_wr_q.push_back({32'h2000, 8'hEF}); exp_wr_q.push_back({32'h2001, 8'hBE});
        exp_wr_q.push_back({32'h2002, 8'hAD}); exp_wr_q.push_back({32'h2003, 8'hDE});
        run_txn(1'b1, 1'b1, 2'd3, 32'h2000, 32'hDEADBEEF, 0, 0, 0, dc, rd);
        total++;
        if (dc !== 5) begin bad++; $display("FAIL st4_done_cycle: got %0d want 5", dc); end
        n = 0;
        for (int c = 1; c < 40; c++) begin
            if (wr_tr[c] && exp_wr_q.size() > 0) begin
                e = exp_wr_q.pop_front(); n++;
                total++;
                if ({a_tr[c], d_tr[c]} !== e || c !== n) begin
                    bad++; $display("FAIL st4_byte: cyc=%0d a=%h d=%h want cyc %0d %h", c, a_tr[c], d_tr[c], n, e);
                end
            end
        end
        total++;
        if (n !== 4) begin bad++; $display("FAIL st4_count: got %0d want 4", n); end
        exp_wr_q.push_back({32'h2200, 8'hCD}); exp_wr_q.push_back({32'h2201, 8'hAB});
        run_txn(1'b1, 1'b1, 2'd1, 32'h2200, 32'h1234ABCD, 0, 0, 0, dc, rd);
        total++;
        if (dc !== 3) begin bad++; $display("FAIL st2_done_cycle: got %0d want 3", dc); end
        n = 0;
        for (int c = 1; c < 40; c++) begin
            if (wr_tr[c] && exp_wr_q.size() > 0) begin
                e = exp_wr_q.pop_front(); n++;
                total++;
                if ({a_tr[c], d_tr[c]} !== e) begin
                    bad++; $display("FAIL st2_byte: a=%h d=%h want %h", a_tr[c], d_tr[c], e);
                end
            end
        end
        total++;
        if (n !== 2) begin bad++; $display("FAIL st2_count: got %0d want 2", n); end
        exp_q.push_back(32'h000000AB);
        run_txn(1'b1, 1'b0, 2'd0, 32'h2201, 32'h0, 0, 0, 0, dc, rd);
        ed = exp_q.pop_front();
        total++;
        if (dc !== 3 || rd !== ed) begin
            bad++; $display("FAIL ld1_readback: cyc=%0d data=%h want 3/%h", dc, rd, ed);
        end
    endtask

    task automatic test_wrap();
        int dc; logic [31:0] rd; logic [31:0] e;
        exp_q.push_back(32'h00003CA5);
        run_txn(1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 0, 0, 0, dc, rd);
        total++;
        if (a_tr[1] !== 32'hFFFFFFFF || a_tr[2] !== 32'h0) begin
            bad++; $display("FAIL wrap_addr: got %h,%h want ffffffff,00000000", a_tr[1], a_tr[2]);
        end
        e = exp_q.pop_front();
        total++;
        if (dc !== 4 || rd !== e) begin bad++; $display("FAIL wrap_data: cyc=%0d data=%h want 4/%h", dc, rd, e); end
    endtask

    task automatic test_starve();
        int n; logic [32:0] got; logic [32:0] e;
        exp_s_q.push_back({1'b0, 32'hEF}); exp_s_q.push_back({1'b0, 32'hEF});
        exp_s_q.push_back({1'b1, 32'h13}); exp_s_q.push_back({1'b0, 32'hEF});
        exp_s_q.push_back({1'b0, 32'hEF}); exp_s_q.push_back({1'b1, 32'h13});
        @(negedge clk_in);
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h1000;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk_in);
            if (ls_done || if_done) begin
                got = if_done ? {1'b1, if_data} : {1'b0, ls_rdata};
                e = exp_s_q.pop_front(); n++;
                total++;
                if (got !== e) begin bad++; $display("FAIL starve_grant[%0d]: got if=%b %h want if=%b %h", n, got[32], got[31:0], e[32], e[31:0]); end
            end
        end
        ls_req = 1'b0; if_req = 1'b0;
        total++;
        if (n !== 6) begin bad++; $display("FAIL starve_timeout: got %0d grants want 6", n); end
        exp_s_q.delete();
        repeat (8) @(negedge clk_in);
    endtask

    task automatic test_clear();
        int dc; int c; logic [31:0] rd;
        run_txn(1'b0, 1'b0, 2'd3, 32'h1000, 32'h0, 2, 0, 0, dc, rd);
        total++;
        if (dc !== 0) begin bad++; $display("FAIL clear_read_done: got cycle %0d want none", dc); end
        total++;
        if (a_tr[2] !== 32'h1001 || a_tr[3] !== 32'h0) begin
            bad++; $display("FAIL clear_read_idle: a2=%h a3=%h want 00001001,00000000", a_tr[2], a_tr[3]);
        end
        run_txn(1'b1, 1'b1, 2'd3, 32'h2300, 32'h11223344, 2, 0, 0, dc, rd);
        total++;
        if (dc !== 5 || ram_rd(16'h2303) !== 8'h11) begin
            bad++; $display("FAIL clear_write: cyc=%0d byte3=%h want 5/11", dc, ram_rd(16'h2303));
        end
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h1000; clear_in = 1'b1;
        @(negedge clk_in);
        total++;
        if (mem_a !== 32'h0) begin bad++; $display("FAIL clear_idle_block: a=%h want 0", mem_a); end
        clear_in = 1'b0;
        @(negedge clk_in);
        total++;
        if (mem_a !== 32'h1000) begin bad++; $display("FAIL clear_idle_grant: a=%h want 00001000", mem_a); end
        c = 0;
        while (!if_done && c < 20) begin @(negedge clk_in); c++; end
        if_req = 1'b0;
        total++;
        if (if_done !== 1'b1 || if_data !== 32'h13) begin
            bad++; $display("FAIL clear_idle_data: done=%b data=%h want 1/00000013", if_done, if_data);
        end
    endtask

    task automatic test_io_stall();
        int dc; int exp_dc; int exp_wc; int n; logic [31:0] rd; logic [39:0] e;
`ifdef MEM_ARB_IO_STALL_EN
        exp_dc = 5; exp_wc = 4;
`else
        exp_dc = 2; exp_wc = 1;
`endif
        exp_wr_q.push_back({32'h30000, 8'h5A});
        run_txn(1'b1, 1'b1, 2'd0, 32'h30000, 32'h5A, 0, 3, 0, dc, rd);
        total++;
        if (dc !== exp_dc) begin bad++; $display("FAIL io_done_cycle: got %0d want %0d", dc, exp_dc); end
        n = 0;
        for (int c = 1; c < 40; c++) begin
            if (wr_tr[c] && exp_wr_q.size() > 0) begin
                e = exp_wr_q.pop_front(); n++;
                total++;
                if ({a_tr[c], d_tr[c]} !== e || c !== exp_wc) begin
                    bad++; $display("FAIL io_write: cyc=%0d a=%h d=%h want cyc %0d %h", c, a_tr[c], d_tr[c], exp_wc, e);
                end
            end
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL io_write_count: got %0d want 1", n); end
        run_txn(1'b1, 1'b1, 2'd0, 32'h30001, 32'hC3, 0, 0, 0, dc, rd);
        total++;
        if (dc !== 2 || wr_tr[1] !== 1'b1 || d_tr[1] !== 8'hC3) begin
            bad++; $display("FAIL io_nofull: cyc=%0d wr1=%b d1=%h want 2/1/c3", dc, wr_tr[1], d_tr[1]);
        end
    endtask

    task automatic test_freeze();
        int dc; logic [31:0] rd;
        run_txn(1'b1, 1'b1, 2'd3, 32'h2400, 32'hCAFEF00D, 0, 0, 2, dc, rd);
        total++;
        if (dc !== 7) begin bad++; $display("FAIL freeze_done_cycle: got %0d want 7", dc); end
        total++;
        if (a_tr[4] !== 32'h2401 || wr_tr[4] !== 1'b1 || a_tr[5] !== 32'h2402 || d_tr[5] !== 8'hFE) begin
            bad++; $display("FAIL freeze_hold: a4=%h wr4=%b a5=%h d5=%h want 00002401/1/00002402/fe", a_tr[4], wr_tr[4], a_tr[5], d_tr[5]);
        end
        total++;
        if (ram_rd(16'h2403) !== 8'hCA) begin bad++; $display("FAIL freeze_ram: got %h want ca", ram_rd(16'h2403)); end
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk_in);
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h2100; ls_wdata = 32'h99887766;
        @(posedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        total++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            bad++; $display("FAIL async_reset_outs: wr=%b a=%h d=%h want 0/0/0", mem_wr, mem_a, mem_dout);
        end
        ls_req = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk_in);
            if (mem_wr) n++;
        end
        total++;
        if (n !== 0) begin bad++; $display("FAIL async_reset_hold: %0d write cycles want 0", n); end
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        total++;
        if (ram_rd(16'h2101) !== 8'h00 || ram_rd(16'h2100) !== 8'h66) begin
            bad++; $display("FAIL async_reset_lost: 2100=%h 2101=%h want 66/00", ram_rd(16'h2100), ram_rd(16'h2101));
        end
    endtask

    initial begin
        #1 rst_in = 1'b1;
        test_reset();
        test_if_read();
        test_ls_store();
        test_wrap();
        test_starve();
        test_clear();
        test_io_stall();
        test_freeze();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
